// File: rtl/relobi_r_ecc_fifo.sv
// ECC-protected R-channel response FIFO: rdata and packed r_other are stored as separate Hsiao
// SEC/DED codewords and decoded at the head, with error flags, saturating counters and injection.

package relobi_r_ecc_fifo_pkg;
  // Smallest number of check bits whose odd-weight (>=3) columns can cover k data bits
  function automatic int unsigned min_ecc(input int unsigned k);
    int unsigned r;
    r = 2;
    while (((32'd1 << (r - 1)) - r) < k) r++;
    return r;
  endfunction

  // idx-th odd-weight (>=3) r-bit column of the Hsiao parity-check matrix
  function automatic int unsigned hcol(input int unsigned idx, input int unsigned r);
    int unsigned n;
    n = 0;
    for (int unsigned v = 0; v < (32'd1 << r); v++) begin
      if (($countones(v) >= 3) && ($countones(v) % 2 == 1)) begin
        if (n == idx) return v;
        n++;
      end
    end
    return 0;
  endfunction
endpackage

module relobi_r_ecc_enc #(
  parameter int unsigned K = 32,
  localparam int unsigned R = relobi_r_ecc_fifo_pkg::min_ecc(K)
) (
  input  logic [K-1:0] data_i,
  output logic [R-1:0] ecc_o
);
  logic [R-1:0] col [K];

  for (genvar i = 0; i < K; i++) begin : g_col
    assign col[i] = R'(relobi_r_ecc_fifo_pkg::hcol(i, R));
  end

  always_comb begin
    ecc_o = '0;
    for (int i = 0; i < K; i++) begin
      if (data_i[i]) ecc_o = ecc_o ^ col[i];
    end
  end
endmodule

module relobi_r_ecc_dec #(
  parameter int unsigned K = 32,
  localparam int unsigned R = relobi_r_ecc_fifo_pkg::min_ecc(K)
) (
  input  logic [K+R-1:0] code_i,
  output logic [K-1:0]   data_o,
  output logic           single_o,
  output logic           double_o
);
  logic [R-1:0] ecc_calc;
  logic [R-1:0] syn;
  logic [K-1:0] flip;

  relobi_r_ecc_enc #(.K(K)) u_enc (
    .data_i (code_i[K-1:0]),
    .ecc_o  (ecc_calc)
  );

  assign syn = ecc_calc ^ code_i[K+:R];

  for (genvar i = 0; i < K; i++) begin : g_flip
    assign flip[i] = (syn == R'(relobi_r_ecc_fifo_pkg::hcol(i, R)));
  end

  // Odd syndrome is correctable only if it names a data column or a single check bit
  assign single_o = (syn != '0) && (^syn) && ((|flip) || ((syn & (syn - R'(1))) == '0));
  assign double_o = (syn != '0) && !single_o;
  assign data_o   = double_o ? code_i[K-1:0] : (code_i[K-1:0] ^ flip);
endmodule

module relobi_r_ecc_fifo
  import relobi_r_ecc_fifo_pkg::*;
#(
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned OtherWidth = 8,
  parameter int unsigned Depth      = 4,
  parameter int unsigned CntWidth   = 8,
  localparam int unsigned EccD       = min_ecc(DataWidth),
  localparam int unsigned UsageWidth = $clog2(Depth + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [DataWidth-1:0]      in_rdata_i,
  input  logic [OtherWidth-1:0]     in_other_i,
  input  logic [DataWidth+EccD-1:0] inj_mask_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [DataWidth-1:0]      out_rdata_o,
  output logic [OtherWidth-1:0]     out_other_o,
  output logic                      single_err_o,
  output logic                      double_err_o,
  input  logic                      clear_cnt_i,
  output logic [CntWidth-1:0]       sec_cnt_o,
  output logic [CntWidth-1:0]       ded_cnt_o,
  output logic [UsageWidth-1:0]     usage_o
);
  localparam int unsigned EccO     = min_ecc(OtherWidth);
  localparam int unsigned DCodeW   = DataWidth + EccD;
  localparam int unsigned OCodeW   = OtherWidth + EccO;
  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

  logic [DCodeW-1:0]     mem_d [Depth];
  logic [OCodeW-1:0]     mem_o [Depth];
  logic [PtrWidth-1:0]   wr_ptr, rd_ptr;
  logic [UsageWidth-1:0] usage_q;
  logic [CntWidth-1:0]   sec_q, ded_q;
  logic [EccD-1:0]       enc_d;
  logic [EccO-1:0]       enc_o;
  logic                  push, pop;
  logic                  d_single, d_double, o_single, o_double;

  assign in_ready_o  = (usage_q != UsageWidth'(Depth));
  assign out_valid_o = (usage_q != '0);
  assign push        = in_valid_i && in_ready_o && !flush_i;
  assign pop         = out_valid_o && out_ready_i && !flush_i;

  relobi_r_ecc_enc #(.K(DataWidth)) u_enc_d (.data_i(in_rdata_i), .ecc_o(enc_d));
  relobi_r_ecc_enc #(.K(OtherWidth)) u_enc_o (.data_i(in_other_i), .ecc_o(enc_o));

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_d[wr_ptr] <= {enc_d, in_rdata_i} ^ inj_mask_i;
      mem_o[wr_ptr] <= {enc_o, in_other_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      usage_q <= '0;
    end else if (flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      usage_q <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PtrWidth'(Depth - 1)) ? '0 : wr_ptr + PtrWidth'(1);
      if (pop)  rd_ptr <= (rd_ptr == PtrWidth'(Depth - 1)) ? '0 : rd_ptr + PtrWidth'(1);
      if (push && !pop)      usage_q <= usage_q + UsageWidth'(1);
      else if (pop && !push) usage_q <= usage_q - UsageWidth'(1);
    end
  end

  relobi_r_ecc_dec #(.K(DataWidth)) u_dec_d (
    .code_i   (mem_d[rd_ptr]),
    .data_o   (out_rdata_o),
    .single_o (d_single),
    .double_o (d_double)
  );

  relobi_r_ecc_dec #(.K(OtherWidth)) u_dec_o (
    .code_i   (mem_o[rd_ptr]),
    .data_o   (out_other_o),
    .single_o (o_single),
    .double_o (o_double)
  );

  // An uncorrectable codeword anywhere in the entry masks a correctable one in the other
  assign double_err_o = out_valid_o && (d_double || o_double);
  assign single_err_o = out_valid_o && (d_single || o_single) && !(d_double || o_double);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sec_q <= '0;
      ded_q <= '0;
    end else if (clear_cnt_i) begin
      sec_q <= '0;
      ded_q <= '0;
    end else begin
      if (pop && single_err_o && !(&sec_q)) sec_q <= sec_q + CntWidth'(1);
      if (pop && double_err_o && !(&ded_q)) ded_q <= ded_q + CntWidth'(1);
    end
  end

  assign sec_cnt_o = sec_q;
  assign ded_cnt_o = ded_q;
  assign usage_o   = usage_q;
endmodule

// File: tb/tb_relobi_r_ecc_fifo.sv
// Directed bench for relobi_r_ecc_fifo: vector table for FIFO flow plus hand sequences for
// ECC injection, counter stalls/saturation/clear, flush and mid-traffic reset.

module tb_relobi_r_ecc_fifo;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_rdata;
  logic [7:0]  in_other;
  logic [38:0] inj_mask;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic [7:0]  out_other;
  logic        single_err;
  logic        double_err;
  logic        clear_cnt;
  logic [1:0]  sec_cnt;
  logic [1:0]  ded_cnt;
  logic [2:0]  usage;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        push;
    logic        pop;
    logic [31:0] data;
    logic        exp_valid;
    logic        exp_ready;
    logic [2:0]  exp_usage;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  relobi_r_ecc_fifo #(
    .DataWidth  (32),
    .OtherWidth (8),
    .Depth      (4),
    .CntWidth   (2)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_rdata_i   (in_rdata),
    .in_other_i   (in_other),
    .inj_mask_i   (inj_mask),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_rdata_o  (out_rdata),
    .out_other_o  (out_other),
    .single_err_o (single_err),
    .double_err_o (double_err),
    .clear_cnt_i  (clear_cnt),
    .sec_cnt_o    (sec_cnt),
    .ded_cnt_o    (ded_cnt),
    .usage_o      (usage)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] other_of(input logic [31:0] d);
    return d[7:0] ^ 8'h3C;
  endfunction

  task automatic applyStimulus(input logic push, input logic pop, input logic [31:0] d,
                               input logic [7:0] o, input logic [38:0] m,
                               input logic fl, input logic clr);
    in_valid  = push;
    out_ready = pop;
    in_rdata  = d;
    in_other  = o;
    inj_mask  = m;
    flush     = fl;
    clear_cnt = clr;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 32'h0, 8'h0, 39'h0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addVec(input logic push, input logic pop, input logic [31:0] d,
                        input logic ev, input logic er, input logic [2:0] eu,
                        input logic [31:0] erd);
    vec_t v;
    v.push = push; v.pop = pop; v.data = d;
    v.exp_valid = ev; v.exp_ready = er; v.exp_usage = eu; v.exp_rdata = erd;
    vecs.push_back(v);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #2;
    checkOutput("rst_usage", 64'(usage), 64'd0);
    checkOutput("rst_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_sec", 64'(sec_cnt), 64'd0);
    checkOutput("rst_ded", 64'(ded_cnt), 64'd0);
    checkOutput("rst_single", 64'(single_err), 64'd0);
    checkOutput("rst_double", 64'(double_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Fill to full, attempt a dropped push, then drain with push+pop across the wrap point
    addVec(1, 0, 32'hA5A50001, 0, 1, 0, 32'h0);
    addVec(1, 0, 32'hA5A50002, 1, 1, 1, 32'hA5A50001);
    addVec(1, 0, 32'hA5A50003, 1, 1, 2, 32'hA5A50001);
    addVec(1, 0, 32'hA5A50004, 1, 1, 3, 32'hA5A50001);
    addVec(1, 0, 32'hA5A50005, 1, 0, 4, 32'hA5A50001);
    addVec(0, 1, 32'h0,        1, 0, 4, 32'hA5A50001);
    addVec(0, 1, 32'h0,        1, 1, 3, 32'hA5A50002);
    addVec(1, 1, 32'hB0B00001, 1, 1, 2, 32'hA5A50003);
    addVec(1, 1, 32'hB0B00002, 1, 1, 2, 32'hA5A50004);
    addVec(1, 1, 32'hB0B00003, 1, 1, 2, 32'hB0B00001);
    addVec(0, 1, 32'h0,        1, 1, 2, 32'hB0B00002);
    addVec(0, 1, 32'h0,        1, 1, 1, 32'hB0B00003);
    addVec(0, 0, 32'h0,        0, 1, 0, 32'h0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].push, vecs[i].pop, vecs[i].data, other_of(vecs[i].data),
                    39'h0, 1'b0, 1'b0);
      #4;
      checkOutput($sformatf("v%0d_valid", i), 64'(out_valid), 64'(vecs[i].exp_valid));
      checkOutput($sformatf("v%0d_ready", i), 64'(in_ready), 64'(vecs[i].exp_ready));
      checkOutput($sformatf("v%0d_usage", i), 64'(usage), 64'(vecs[i].exp_usage));
      if (vecs[i].exp_valid) begin
        checkOutput($sformatf("v%0d_rdata", i), 64'(out_rdata), 64'(vecs[i].exp_rdata));
        checkOutput($sformatf("v%0d_other", i), 64'(out_other), 64'(other_of(vecs[i].exp_rdata)));
        checkOutput($sformatf("v%0d_errs", i), 64'({single_err, double_err}), 64'd0);
      end
      tick();
    end
    idle();

    // Single-bit data error, stalled for 3 cycles before the pop
    applyStimulus(1'b1, 1'b0, 32'h12345678, 8'h11, 39'h8, 1'b0, 1'b0);
    tick();
    idle();
    for (int c = 0; c < 3; c++) begin
      #4;
      checkOutput($sformatf("sec_stall%0d_data", c), 64'(out_rdata), 64'h12345678);
      checkOutput($sformatf("sec_stall%0d_single", c), 64'(single_err), 64'd1);
      checkOutput($sformatf("sec_stall%0d_double", c), 64'(double_err), 64'd0);
      checkOutput($sformatf("sec_stall%0d_cnt", c), 64'(sec_cnt), 64'd0);
      tick();
    end
    applyStimulus(1'b0, 1'b1, 32'h0, 8'h0, 39'h0, 1'b0, 1'b0);
    tick();
    idle();
    #4;
    checkOutput("sec_after_pop", 64'(sec_cnt), 64'd1);
    checkOutput("sec_empty", 64'(out_valid), 64'd0);
    tick();

    // Double-bit data error: raw data passes through, other field intact
    applyStimulus(1'b1, 1'b0, 32'hDEADBEEF, 8'h5A, 39'h3, 1'b0, 1'b0);
    tick();
    idle();
    #4;
    checkOutput("ded_double", 64'(double_err), 64'd1);
    checkOutput("ded_single", 64'(single_err), 64'd0);
    checkOutput("ded_other", 64'(out_other), 64'h5A);
    checkOutput("ded_rawdata", 64'(out_rdata), 64'hDEADBEEC);
    tick();
    applyStimulus(1'b0, 1'b1, 32'h0, 8'h0, 39'h0, 1'b0, 1'b0);
    tick();
    idle();
    #4;
    checkOutput("ded_cnt", 64'(ded_cnt), 64'd1);
    checkOutput("ded_sec_kept", 64'(sec_cnt), 64'd1);
    tick();

    // Flush beats a same-cycle push; counters survive
    applyStimulus(1'b1, 1'b0, 32'h11, 8'h01, 39'h0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h22, 8'h02, 39'h0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h33, 8'h03, 39'h0, 1'b1, 1'b0);
    tick();
    idle();
    #4;
    checkOutput("flush_usage", 64'(usage), 64'd0);
    checkOutput("flush_valid", 64'(out_valid), 64'd0);
    checkOutput("flush_ready", 64'(in_ready), 64'd1);
    checkOutput("flush_cnts", 64'({sec_cnt, ded_cnt}), 64'h5);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h44, 8'h04, 39'h0, 1'b0, 1'b0);
    tick();
    idle();
    #4;
    checkOutput("postflush_usage", 64'(usage), 64'd1);
    checkOutput("postflush_data", 64'(out_rdata), 64'h44);
    tick();

    // Reset mid-traffic with three entries queued
    applyStimulus(1'b1, 1'b0, 32'h55, 8'h05, 39'h0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h66, 8'h06, 39'h0, 1'b0, 1'b0);
    tick();
    idle();
    #4;
    checkOutput("prerst_usage", 64'(usage), 64'd3);
    tick();
    rst_n = 1'b0;
    tick();
    checkOutput("midrst_usage", 64'(usage), 64'd0);
    checkOutput("midrst_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_ready", 64'(in_ready), 64'd1);
    checkOutput("midrst_cnts", 64'({sec_cnt, ded_cnt}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Five correctable pops saturate the 2-bit counter; the last one hits a check bit
    for (int k = 0; k < 5; k++) begin
      logic [38:0] m;
      logic [31:0] d;
      m = (k == 4) ? (39'h1 << 34) : (39'h1 << (k * 5));
      d = 32'h00C0FFE0 + 32'(k);
      applyStimulus(1'b1, 1'b0, d, other_of(d), m, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b1, 32'h0, 8'h0, 39'h0, 1'b0, 1'b0);
      #4;
      checkOutput($sformatf("sat%0d_data", k), 64'(out_rdata), 64'(d));
      checkOutput($sformatf("sat%0d_single", k), 64'(single_err), 64'd1);
      tick();
      idle();
      #4;
      checkOutput($sformatf("sat%0d_cnt", k), 64'(sec_cnt), 64'((k + 1 > 3) ? 3 : k + 1));
      tick();
    end
    applyStimulus(1'b1, 1'b0, 32'h0BADF00D, 8'h77, 39'h1 << 7, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 32'h0, 8'h0, 39'h0, 1'b0, 1'b1);
    #4;
    checkOutput("clr_single", 64'(single_err), 64'd1);
    tick();
    idle();
    #4;
    checkOutput("clr_sec", 64'(sec_cnt), 64'd0);
    checkOutput("clr_empty", 64'(out_valid), 64'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
